// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   // Even parity bit; zero-extension of narrower data leaves the result unchanged.
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle for the multiport register file: write port, two read ports, clear and parity status.
interface regfile_multiport_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) ();
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              err_inject;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [DATA_W-1:0] rd_data_a;
   logic              par_err_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_b;
   logic              par_err_b;
   logic              clr_req;
   logic              busy;

   modport master (
      output wr_en, wr_addr, wr_data, err_inject, rd_addr_a, rd_addr_b, clr_req,
      input  rd_data_a, par_err_a, rd_data_b, par_err_b, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, err_inject, rd_addr_a, rd_addr_b, clr_req,
      output rd_data_a, par_err_a, rd_data_b, par_err_b, busy
   );
endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: bypass, zero-register and clear masking, optional parity check.
// Parity checking is compiled in when REGFILE_PARITY_EN is defined.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_par,
   input  logic              wr_accept,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clearing,
   output logic [DATA_W-1:0] rd_data,
   output logic              par_err
);
   logic [DATA_W-1:0] rd_data_reg, rd_data_next;
   logic              par_err_reg, par_err_next;
   logic              zero_hit, bypass_hit;

   assign zero_hit   = ZERO_R0 && (rd_addr == '0);
   // wr_accept already excludes clear requests and writes to a hardwired zero register
   assign bypass_hit = wr_accept && (wr_addr == rd_addr);

   always_comb begin
      rd_data_next = mem_data;
      par_err_next = 1'b0;
      if (clearing || zero_hit) begin
         rd_data_next = '0;
      end else if (bypass_hit) begin
         rd_data_next = wr_data;
      end
`ifdef REGFILE_PARITY_EN
      else begin
         par_err_next = (even_parity(64'(mem_data)) != mem_par);
      end
`endif
   end

`ifndef REGFILE_PARITY_EN
   logic unused_par;
   assign unused_par = mem_par;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_reg <= '0;
         par_err_reg <= 1'b0;
      end else begin
         rd_data_reg <= rd_data_next;
         par_err_reg <= par_err_next;
      end
   end

   assign rd_data = rd_data_reg;
   assign par_err = par_err_reg;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: one write port, two registered read ports, multi-cycle bulk clear.
// Optional per-register parity protection is enabled by defining REGFILE_PARITY_EN.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   regfile_multiport_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   state_t                       state_reg, state_next;
   logic [ADDR_W-1:0]            ptr_reg, ptr_next;
   logic [DEPTH-1:0][DATA_W-1:0] mem_reg;
   logic [DEPTH-1:0]             par_reg;
   logic [DEPTH-1:0]             wr_sel, clr_sel;
   logic                         clearing, wr_accept;

   assign clearing  = (state_reg == CLEAR);
   // A clear request in the same cycle takes priority and drops the write
   assign wr_accept = bus.wr_en && !clearing && !bus.clr_req &&
                      !(ZERO_R0 && (bus.wr_addr == '0));
   assign bus.busy  = clearing;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (bus.clr_req) begin
               state_next = CLEAR;
               ptr_next   = '0;
            end
         end
         CLEAR: begin
            if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
               state_next = IDLE;
               ptr_next   = '0;
            end else begin
               ptr_next = ptr_reg + ADDR_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign wr_sel[gi]  = wr_accept && (bus.wr_addr == ADDR_W'(gi));
      assign clr_sel[gi] = clearing && (ptr_reg == ADDR_W'(gi));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_reg <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clr_sel[i]) begin
               mem_reg[i] <= '0;
            end else if (wr_sel[i]) begin
               mem_reg[i] <= bus.wr_data;
            end
         end
      end
   end

`ifdef REGFILE_PARITY_EN
   logic wr_par;
   assign wr_par = even_parity(64'(bus.wr_data)) ^ bus.err_inject;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_reg <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clr_sel[i]) begin
               par_reg[i] <= 1'b0;
            end else if (wr_sel[i]) begin
               par_reg[i] <= wr_par;
            end
         end
      end
   end
`else
   logic unused_inject;
   assign unused_inject = bus.err_inject;
   assign par_reg       = '0;
`endif

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
   ) u_port_a (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (bus.rd_addr_a),
      .mem_data (mem_reg[bus.rd_addr_a]),
      .mem_par  (par_reg[bus.rd_addr_a]),
      .wr_accept(wr_accept),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .clearing (clearing),
      .rd_data  (bus.rd_data_a),
      .par_err  (bus.par_err_a)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
   ) u_port_b (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (bus.rd_addr_b),
      .mem_data (mem_reg[bus.rd_addr_b]),
      .mem_par  (par_reg[bus.rd_addr_b]),
      .wr_accept(wr_accept),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .clearing (clearing),
      .rd_data  (bus.rd_data_b),
      .par_err  (bus.par_err_b)
   );

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: directed scenarios plus randomized traffic
// compared against a behavioural model of the register file.
module tb_regfile_multiport;
   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 3;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam bit ZERO_R0 = 1'b1;
`ifdef REGFILE_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   regfile_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_multiport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: register contents, "stored parity is bad" flags, clear cycles remaining
   logic [DATA_W-1:0] model_mem [DEPTH];
   bit                model_bad [DEPTH];
   int                busy_left;
   logic [DATA_W-1:0] exp_a, exp_b;
   bit                exp_err_a, exp_err_b;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = '0;
         model_bad[i] = 1'b0;
      end
      busy_left = 0;
      exp_a = '0; exp_b = '0;
      exp_err_a = 1'b0; exp_err_b = 1'b0;
   endtask

   task automatic predict(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] d, output bit e);
      d = '0;
      e = 1'b0;
      if (busy_left > 0) begin
         d = '0;
      end else if (ZERO_R0 && addr == 0) begin
         d = '0;
      end else if (bus.wr_en && !bus.clr_req && bus.wr_addr == addr) begin
         d = bus.wr_data;
      end else begin
         d = model_mem[addr];
         e = PAR_EN && model_bad[addr];
      end
   endtask

   task automatic model_step();
      predict(bus.rd_addr_a, exp_a, exp_err_a);
      predict(bus.rd_addr_b, exp_b, exp_err_b);
      if (busy_left > 0) begin
         busy_left--;
      end else if (bus.clr_req) begin
         for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            model_bad[i] = 1'b0;
         end
         busy_left = DEPTH;
      end else if (bus.wr_en && !(ZERO_R0 && bus.wr_addr == 0)) begin
         model_mem[bus.wr_addr] = bus.wr_data;
         model_bad[bus.wr_addr] = bus.err_inject;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "/rd_a"},  32'(bus.rd_data_a), 32'(exp_a));
      check_val({tag, "/rd_b"},  32'(bus.rd_data_b), 32'(exp_b));
      check_val({tag, "/perr_a"}, 32'(bus.par_err_a), 32'(exp_err_a));
      check_val({tag, "/perr_b"}, 32'(bus.par_err_b), 32'(exp_err_b));
      check_val({tag, "/busy"},  32'(bus.busy), 32'(busy_left > 0));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input bit we, input int wa, input int wd, input bit inj,
                        input int ra, input int rb, input bit clr);
      bus.wr_en      = we;
      bus.wr_addr    = ADDR_W'(wa);
      bus.wr_data    = DATA_W'(wd);
      bus.err_inject = inj;
      bus.rd_addr_a  = ADDR_W'(ra);
      bus.rd_addr_b  = ADDR_W'(rb);
      bus.clr_req    = clr;
   endtask

   int busy_cycles;

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      tick("reset");
      tick("reset");
      reset = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, i, DEPTH - 1 - i, 0);
         tick("init_rd");
      end

      // Write r3, then read r3 / r0; r0 ignores writes
      drive(1, 3, 8'h5A, 0, 1, 2, 0);  tick("wr_r3");
      drive(0, 0, 0, 0, 3, 0, 0);      tick("rd_r3");
      drive(1, 0, 8'h77, 0, 3, 0, 0);  tick("wr_r0");
      drive(0, 0, 0, 0, 0, 0, 0);      tick("rd_r0");

      // Bypass on both ports to the same address
      drive(1, 5, 8'h11, 0, 0, 0, 0);  tick("wr_r5");
      drive(1, 5, 8'hC3, 0, 5, 5, 0);  tick("bypass_r5");
      drive(0, 0, 0, 0, 5, 5, 0);      tick("rd_r5");

      // Fill r1..r7, then clear with a simultaneous write and a pre-clear read
      for (int i = 1; i < DEPTH; i++) begin
         drive(1, i, i, 0, i - 1, i, 0);
         tick("fill");
      end
      drive(1, 1, 8'h99, 0, 3, 1, 1);
      tick("clr_start");
      busy_cycles = bus.busy ? 1 : 0;
      for (int k = 0; k < 20 && bus.busy; k++) begin
         drive(k == 1, 2, 8'hFF, 0, $urandom_range(0, DEPTH - 1), 2, k == 3);
         tick("clr_busy");
         if (bus.busy) busy_cycles++;
      end
      check_val("busy_len", 32'(busy_cycles), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, i, DEPTH - 1 - i, 0);
         tick("post_clr");
      end

      // Reset in the 4th busy cycle
      drive(1, 6, 8'h3C, 0, 6, 6, 0); tick("pre_wr_r6");
      drive(0, 0, 0, 0, 6, 6, 1);     tick("clr2");
      drive(0, 0, 0, 0, 6, 6, 0);
      tick("clr2_busy");
      tick("clr2_busy");
      tick("clr2_busy");
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      tick("rst_hold");
      reset = 1'b0;
      drive(1, 6, 8'h3C, 0, 1, 2, 0); tick("wr_r6");
      drive(0, 0, 0, 0, 6, 6, 0);     tick("rd_r6");

      // Parity injection, bypass with injection, and clean rewrite
      drive(1, 4, 8'h0F, 1, 0, 0, 0); tick("inj_wr_r4");
      drive(0, 0, 0, 0, 4, 4, 0);     tick("inj_rd_r4");
      drive(1, 4, 8'h0F, 1, 4, 1, 0); tick("inj_bypass_r4");
      drive(1, 4, 8'h0F, 0, 4, 0, 0); tick("clean_wr_r4");
      drive(0, 0, 0, 0, 4, 4, 0);     tick("clean_rd_r4");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
               ($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, DEPTH - 1), ($urandom_range(0, 39) == 0));
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the two-register 4-bit file: DEPTH registers of DATA_W bits, one write port and two independent registered read ports (A, B).
- Adds the following:
  - write-to-read bypass;
  - an optional hardwired-zero register 0;
  - a multi-cycle bulk-clear sequencer with a busy flag.
- Sits between the mini CPU decode stage (read addresses) and writeback (write port).

Parameters:
- DATA_W, 8, register width in bits (≥1).
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- ZERO_R0, 1, when 1, register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe, sampled on the rising edge.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data (registered).
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data (registered).
- clr_req  in  1  single-cycle request to zero all registers.
- busy  out  1  high while a clear sequence is running.
- par_err_a  out  1  parity error on port A (see Optional Feature).
- par_err_b  out  1  parity error on port B (see Optional Feature).
- err_inject  in  1  corrupts the stored parity of the current write (see Optional Feature).

Behaviour:
- Clock/reset: clk; reset is asynchronous and active-high.
- Reset values: all registers = 0, rd_data_a = rd_data_b = 0, busy = 0, par_err_a = par_err_b = 0, FSM = IDLE, clear pointer = 0.
- Write: when wr_en = 1 and FSM = IDLE, mem[wr_addr] <= wr_data at the edge. If ZERO_R0 = 1 and wr_addr = 0, the write is dropped.
- Read latency: 1 cycle. rd_data_x at edge n+1 reflects rd_addr_x sampled at edge n.
- Bypass: if wr_en = 1, FSM = IDLE and wr_addr == rd_addr_x in the same cycle, rd_data_x = wr_data at the next edge, not the old contents. Bypass is suppressed for address 0 when ZERO_R0 = 1.
- Both ports may read the same address, including a bypassed one; both return identical data.
- ZERO_R0 = 1: reads of address 0 return 0 regardless of history.
- FSM, two states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req = 1. busy goes high at the next edge, and the pointer is loaded with 0.
  - CLEAR: each cycle writes mem[ptr] = 0, then ptr = ptr + 1.
  - When ptr = DEPTH-1 has been cleared, CLEAR -> IDLE; busy drops at that edge.
  - Total busy duration: exactly DEPTH cycles.
- During CLEAR:
  - wr_en is ignored; the write is lost, with no queueing.
  - Both read ports return 0.
  - clr_req is ignored; it does not restart or extend the sequence.
- clr_req and wr_en together in IDLE: the clear wins and the write is dropped. A read issued in that cycle returns the pre-clear value (bypass disabled).
- Reset mid-CLEAR: immediate return to IDLE, busy = 0, all registers 0.
- Address arithmetic is unsigned ADDR_W bits. The pointer must not wrap past DEPTH-1 into a second pass.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit computed from wr_data at write time.
  - err_inject = 1 during a write stores the inverted parity.
  - Each read port recomputes parity. par_err_x is registered with the same 1-cycle latency as rd_data_x, and is 1 on mismatch.
  - Bypassed reads use the freshly computed parity, so inject does not flag on a bypass.
  - Clear writes parity 0, which is correct for zero data.
  - Register 0 with ZERO_R0 = 1 never flags.
- Not defined: no parity storage; par_err_a and par_err_b are tied to 0; err_inject is unused. Ports remain present so the bench is shared.

Decomposition:
- Shared package regfile_pkg:
  - FSM state typedef (IDLE, CLEAR);
  - default DATA_W/ADDR_W constants;
  - even-parity function.
- One natural sub-module: regfile_read_port, instantiated twice. It handles address register, bypass compare, zero-reg masking, busy masking and parity check.
- Storage, write logic and the clear FSM stay in the top level.

Test Plan:
- Reset, then read all 8 addresses on both ports -> every rd_data = 0x00, busy = 0, par_err = 0.
- Write 0x5A to r3; next cycle read r3 on port A and r0 on port B -> A = 0x5A, B = 0x00. Then write 0x77 to r0 -> reading r0 still returns 0x00.
- Same cycle: wr_addr = 5, wr_data = 0xC3, rd_addr_a = rd_addr_b = 5 (old contents 0x11) -> both ports return 0xC3 on the next edge.
- Fill r1..r7 with 0x01..0x07, pulse clr_req -> busy is high for exactly 8 cycles. A write of 0xFF to r2 during busy is lost. Reads during busy = 0. After busy falls, all registers read 0x00.
- Pulse clr_req, assert reset in the 4th busy cycle -> busy = 0 immediately. A subsequent write/read of r6 = 0x3C works normally.
- With REGFILE_PARITY_EN: write 0x0F to r4 with err_inject = 1, read r4 next cycle -> rd_data_a = 0x0F, par_err_a = 1. Rewrite r4 without inject -> par_err_a = 0. Without the macro, the same sequence -> par_err_a = 0.
